// File: rtl/saturn_char_uart_tx.sv
`timescale 1ns/1ps
// saturn_char_uart_tx
// Buffers characters from the bus character stream in a small FIFO and
// serialises them as UART frames (8N1, or 8E1 when SATURN_UART_PARITY_EN
// is defined) on a single TX pin at CLK_HZ/BAUD cycles per bit.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   i_char     character byte, sampled only on an accepted write
//   i_char_wr  write strobe, one character per high cycle
//   o_full     FIFO holds 2**FIFO_AW entries
//   o_empty    FIFO holds 0 entries
//   o_busy     a frame is in progress
//   o_overflow sticky: a write was dropped; cleared only by reset
//   o_tx       serial line, idle high
//
// Optional feature macro: SATURN_UART_PARITY_EN (even parity bit between
// the data bits and the stop bit).
module saturn_char_uart_tx #(
    parameter int CLK_HZ  = 25000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_char,
    input  logic       i_char_wr,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_busy,
    output logic       o_overflow,
    output logic       o_tx
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = $clog2(DIV);
    localparam int NW    = FIFO_AW + 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

`ifdef SATURN_UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [NW-1:0]      count;
    logic               overflow_q;
    logic               full;
    logic               empty;
    logic               accept;
    logic               pop;

    assign full   = (count == NW'(DEPTH));
    assign empty  = (count == '0);
    // Acceptance uses the count at the start of the cycle, so a same-cycle
    // pop never frees room for a write into a full FIFO.
    assign accept = i_char_wr && !full;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= i_char;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (accept && !pop) begin
                count <= count + NW'(1);
            end else if (!accept && pop) begin
                count <= count - NW'(1);
            end
            if (i_char_wr && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_done;
`ifdef SATURN_UART_PARITY_EN
    logic          par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef SATURN_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef SATURN_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
`ifdef SATURN_UART_PARITY_EN
        par_d    = par_q;
`endif
        pop      = 1'b0;
        bit_done = (cnt_q == '0);

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
`ifdef SATURN_UART_PARITY_EN
                    // Parity is captured at pop because the shift register
                    // has emptied by the time the parity bit goes out.
                    par_d   = ^mem[rd_ptr];
`endif
                    cnt_d   = DIV_M1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d   = DIV_M1;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d   = DIV_M1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef SATURN_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef SATURN_UART_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d   = DIV_M1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Line level is decoded purely from registered state.
    always_comb begin
        o_tx = 1'b1;
        case (state_q)
            S_START:  o_tx = 1'b0;
            S_DATA:   o_tx = shift_q[0];
`ifdef SATURN_UART_PARITY_EN
            S_PARITY: o_tx = par_q;
`endif
            default:  o_tx = 1'b1;
        endcase
    end

    assign o_full     = full;
    assign o_empty    = empty;
    assign o_busy     = (state_q != S_IDLE);
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_saturn_char_uart_tx.sv
`timescale 1ns/1ps
module tb_saturn_char_uart_tx;

    localparam int DIV   = 10;
    localparam int DEPTH = 16;
`ifdef SATURN_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_char = 8'h00;
    logic       i_char_wr = 1'b0;
    logic       o_full, o_empty, o_busy, o_overflow, o_tx;

    saturn_char_uart_tx #(
        .CLK_HZ (1000000),
        .BAUD   (100000),
        .FIFO_AW(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_char    (i_char),
        .i_char_wr (i_char_wr),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_busy    (o_busy),
        .o_overflow(o_overflow),
        .o_tx      (o_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of stored bytes, cycles left in the current
    // frame, sticky overflow, and the scoreboard of bytes now on the wire.
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    int         m_busy = 0;
    logic       m_ovf = 1'b0;
    bit         mon_abort = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic rst);
        bit wok;
        bit pop;
        reset     = rst;
        i_char_wr = wr;
        i_char    = d;
        @(posedge clk);
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_busy    = 0;
            m_ovf     = 1'b0;
            mon_abort = 1'b1;
        end else begin
            wok = wr && (m_fifo.size() < DEPTH);
            pop = (m_busy == 0) && (m_fifo.size() > 0);
            if (wr && !wok) m_ovf = 1'b1;
            if (pop) begin
                exp_q.push_back(m_fifo.pop_front());
                m_busy = FRAME;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            if (wok) m_fifo.push_back(d);
        end
        #1;
        reset     = 1'b0;
        i_char_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((m_fifo.size() != 0 || m_busy != 0) && i < 4000) begin
            step(1'b0, 8'h00, 1'b0);
            i++;
        end
        idle(5);
    endtask

    // Monitor: per-cycle status against the model, and frame decode from the
    // line itself; each complete frame pops the scoreboard.
    bit         mon_active = 1'b0;
    int         mon_cyc = 0;
    int         mon_k = 0;
    logic [7:0] mon_byte = 8'h00;
    logic       mon_par = 1'b0;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (mon_abort) begin
            mon_active = 1'b0;
            mon_abort  = 1'b0;
        end
        chk("busy", o_busy, m_busy != 0);
        chk("empty", o_empty, m_fifo.size() == 0);
        chk("full", o_full, m_fifo.size() == DEPTH);
        chk("overflow", o_overflow, m_ovf);
        if (!mon_active && o_tx == 1'b0) begin
            mon_active = 1'b1;
            mon_cyc    = 0;
            mon_byte   = 8'h00;
            chk("start_latency", m_busy, FRAME);
        end
        if (mon_active) begin
            if (mon_cyc % DIV == DIV / 2) begin
                mon_k = mon_cyc / DIV;
                if (mon_k == 0) chk("start_bit", o_tx, 1'b0);
                else if (mon_k <= 8) mon_byte[mon_k-1] = o_tx;
                else if (mon_k == NBITS - 1) chk("stop_bit", o_tx, 1'b1);
                else mon_par = o_tx;
            end
            if (mon_cyc == FRAME - 1) begin
                mon_active = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %0h expected none at %0t", mon_byte, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("frame_byte", mon_byte, mon_exp);
`ifdef SATURN_UART_PARITY_EN
                    chk("parity_bit", mon_par, ^mon_exp);
`endif
                end
            end else begin
                mon_cyc++;
            end
        end else if (m_busy == 0) begin
            chk("idle_tx", o_tx, 1'b1);
        end
    end

    initial begin
        int gap;
        int len;
        // Reset
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle(3);

        // Single character
        step(1'b1, 8'h41, 1'b0);
        idle(FRAME + 10);
        step(1'b1, 8'h43, 1'b0);
        idle(FRAME + 10);

        // Burst of three
        step(1'b1, 8'h48, 1'b0);
        step(1'b1, 8'h49, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        drain();

        // Hold write for 18 cycles: 17 stored/sent, last dropped
        for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        drain();
        chk("overflow_sticky", o_overflow, 1'b1);

        // Full FIFO, write coincides with the idle pop
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 2 * FRAME && m_busy != 0; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        chk("drop_on_pop_ovf", o_overflow, 1'b1);
        chk("drop_on_pop_full", o_full, 1'b0);
        idle(3 * (FRAME + 1));

        // Reset at the middle of data bit 3
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        idle(DIV + 3 * DIV + DIV / 2);
        step(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("reset_tx", o_tx, 1'b1);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_empty", o_empty, 1'b1);
        idle(2 * FRAME);

        // Randomised traffic
        for (int r = 0; r < 40; r++) begin
            gap = $urandom_range(0, 250);
            len = $urandom_range(1, 20);
            idle(gap);
            for (int i = 0; i < len; i++)
                step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 1'b0);
        end
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
